// File: rtl/role_dealer.sv
// role_dealer: deals hidden roles (villager/wolf/doctor) to NUM_PLAYERS slots from a
// loadable Galois LFSR, using rejection sampling with a bounded lowest-free-slot fallback.
// Output player 0 occupies the two MSBs of roles, matching the legacy seed table layout.
module role_dealer #(
    parameter int unsigned NUM_PLAYERS = 5,
    parameter int unsigned NUM_WOLVES  = 1,
    parameter int unsigned NUM_DOCTORS = 1,
    parameter int unsigned LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400),
    parameter int unsigned MAX_TRIES   = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [LFSR_W-1:0]        seed,
    input  logic                     seed_load,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [2*NUM_PLAYERS-1:0] roles
);

    localparam int unsigned PW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int unsigned TOTAL = NUM_WOLVES + NUM_DOCTORS;
    localparam int unsigned CW    = $clog2(NUM_PLAYERS + 1);
    localparam int unsigned TW    = ($clog2(MAX_TRIES + 1) > 0) ? $clog2(MAX_TRIES + 1) : 1;

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 16 || NUM_WOLVES < 1 || TOTAL > NUM_PLAYERS ||
        LFSR_W < PW) begin : g_bad_params
        $error("role_dealer: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StClear, StPlace, StDone} state_e;

    state_e                       state_q, state_d;
    logic [LFSR_W-1:0]            lfsr_q, lfsr_d;
    logic [NUM_PLAYERS-1:0][1:0]  slot_q, slot_d;
    logic [CW-1:0]                placed_q, placed_d;
    logic [TW-1:0]                tries_q, tries_d;

    logic [PW-1:0]     cand;
    logic              cand_ok;
    logic [PW-1:0]     free_idx;
    logic [1:0]        new_code;
    logic [LFSR_W-1:0] lfsr_step;

    assign cand      = lfsr_q[PW-1:0];
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    assign new_code  = (32'(placed_q) < NUM_WOLVES) ? 2'b01 : 2'b10;

    // Candidate acceptance and lowest-index free slot (fallback target).
    always_comb begin
        cand_ok  = 1'b0;
        free_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (slot_q[i] == 2'b00) begin
                free_idx = PW'(i);
                if (cand == PW'(i)) cand_ok = 1'b1;
            end
        end
    end

    // Next-state logic and busy/done decode.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        slot_d   = slot_q;
        placed_d = placed_q;
        tries_d  = tries_q;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Load lands on the same edge as start, so the deal sees the new seed.
                if (seed_load) lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
                if (start) state_d = StClear;
            end
            StClear: begin
                busy     = 1'b1;
                slot_d   = '0;
                placed_d = '0;
                tries_d  = '0;
                state_d  = StPlace;
            end
            StPlace: begin
                busy   = 1'b1;
                lfsr_d = lfsr_step;
                if (32'(tries_q) == MAX_TRIES) begin
                    slot_d[free_idx] = new_code;
                    placed_d         = placed_q + 1'b1;
                    tries_d          = '0;
                end else if (cand_ok) begin
                    slot_d[cand] = new_code;
                    placed_d     = placed_q + 1'b1;
                    tries_d      = '0;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
                if (32'(placed_d) == TOTAL) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Flatten slots so player 0 lands in the MSBs.
    always_comb begin
        roles = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            roles[2*(NUM_PLAYERS-1-i) +: 2] = slot_q[i];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            lfsr_q   <= LFSR_W'(1);
            slot_q   <= '0;
            placed_q <= '0;
            tries_q  <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            slot_q   <= slot_d;
            placed_q <= placed_d;
            tries_q  <= tries_d;
        end
    end

endmodule

// File: tb/tb_role_dealer.sv
// tb_role_dealer: drives two dealers (default 5/1/1/32 and 8/2/1/4) with identical stimulus
// and checks them against a scoreboard fed by a behavioural model of the deal.
module tb_role_dealer;

    typedef struct {
        logic [31:0] roles;
        int          st;
        int          lat;
        bit          fb;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] seed = '0;
    logic        seed_load = 1'b0;
    logic        start = 1'b0;
    logic        busy5, done5, busy8, done8;
    logic [9:0]  roles5;
    logic [15:0] roles8;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   st5 = 0;
    int   dc5 = 0;
    bit   active5 = 1'b0;
    bit   skip_mon = 1'b0;
    int   fb_seen = 0;
    exp_t q5[$];
    exp_t q8[$];
    exp_t em;
    logic [9:0]  last_roles5 = '0;
    logic [15:0] m5 = 16'h1;
    logic [15:0] m8 = 16'h1;
    logic [9:0]  ra, rb;

    role_dealer u_dut5 (
        .clock     (clock),
        .reset_n   (reset_n),
        .seed      (seed),
        .seed_load (seed_load),
        .start     (start),
        .busy      (busy5),
        .done      (done5),
        .roles     (roles5)
    );

    role_dealer #(
        .NUM_PLAYERS (8),
        .NUM_WOLVES  (2),
        .NUM_DOCTORS (1),
        .MAX_TRIES   (4)
    ) u_dut8 (
        .clock     (clock),
        .reset_n   (reset_n),
        .seed      (seed),
        .seed_load (seed_load),
        .start     (start),
        .busy      (busy8),
        .done      (done8),
        .roles     (roles8)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int count_code(input logic [31:0] r, input int n, input logic [1:0] c);
        int cnt = 0;
        for (int i = 0; i < n; i++) if (r[2*i +: 2] == c) cnt++;
        return cnt;
    endfunction

    // Reference deal: one LFSR step per PLACE cycle, fallback once tries hits the limit.
    task automatic model_deal(input logic [15:0] l_in, input int n, input int nw, input int nd,
                              input int mt, output logic [31:0] r, output int k,
                              output logic [15:0] l_out, output bit fb);
        logic [1:0]  slot [16];
        logic [15:0] l;
        int placed, tries, cand, pick, mask;
        for (int i = 0; i < 16; i++) slot[i] = 2'b00;
        l = l_in; placed = 0; tries = 0; k = 0; fb = 1'b0;
        mask = (1 << $clog2(n)) - 1;
        while (placed < nw + nd) begin
            cand = int'(l) & mask;
            pick = -1;
            if (tries == mt) begin
                for (int i = n - 1; i >= 0; i--) if (slot[i] == 2'b00) pick = i;
                fb = 1'b1;
            end else if (cand < n && slot[cand] == 2'b00) begin
                pick = cand;
            end
            if (pick >= 0) begin
                slot[pick] = (placed < nw) ? 2'b01 : 2'b10;
                placed++;
                tries = 0;
            end else begin
                tries++;
            end
            l = lfsr_next(l);
            k++;
        end
        r = '0;
        for (int i = 0; i < n; i++) r[2*(n-1-i) +: 2] = slot[i];
        l_out = l;
    endtask

    // One deal on both DUTs; optional start/seed_load poke while they are in PLACE.
    task automatic deal(input bit load, input logic [15:0] s, input bit poke);
        exp_t e5, e8;
        logic [15:0] nx;
        int k;
        if (load) begin
            m5 = (s == 16'h0) ? 16'h1 : s;
            m8 = m5;
        end
        model_deal(m5, 5, 1, 1, 32, e5.roles, k, nx, e5.fb);
        m5 = nx; e5.lat = k + 2;
        model_deal(m8, 8, 2, 1, 4, e8.roles, k, nx, e8.fb);
        m8 = nx; e8.lat = k + 2;
        @(posedge clock); #1;
        seed = s; seed_load = load; start = 1'b1;
        e5.st = cyc; e8.st = cyc;
        st5 = cyc; dc5 = cyc + e5.lat; active5 = 1'b1;
        q5.push_back(e5);
        q8.push_back(e8);
        @(posedge clock); #1;
        seed_load = 1'b0; start = 1'b0;
        if (poke) begin
            @(posedge clock); #1;
            seed = 16'h1234; seed_load = 1'b1; start = 1'b1;
            @(posedge clock); #1;
            seed_load = 1'b0; start = 1'b0;
        end
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            if (q5.size() == 0 && q8.size() == 0) break;
        end
        if (q5.size() != 0 || q8.size() != 0) begin
            check_eq("deal_timeout", 32'(q5.size() + q8.size()), 32'd0);
            q5.delete();
            q8.delete();
        end
    endtask

    task automatic apply_reset();
        @(posedge clock); #3;
        reset_n = 1'b0;
        q5.delete(); q8.delete();
        active5 = 1'b0; m5 = 16'h1; m8 = 16'h1;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
    endtask

    // Scoreboard side: per-cycle busy/done for the default DUT, results on every done.
    always @(negedge clock) begin
        if (reset_n && !skip_mon) begin
            check_eq("busy5", 32'(busy5), 32'(active5 && cyc > st5 && cyc < dc5));
            check_eq("done5", 32'(done5), 32'(active5 && cyc == dc5));
            if (done5 && q5.size() > 0) begin
                em = q5.pop_front();
                check_eq("roles5", 32'(roles5), em.roles);
                check_eq("wolves5", count_code(32'(roles5), 5, 2'b01), 32'd1);
                check_eq("doctors5", count_code(32'(roles5), 5, 2'b10), 32'd1);
                check_eq("code11_5", count_code(32'(roles5), 5, 2'b11), 32'd0);
                last_roles5 = roles5;
            end
            if (done8) begin
                if (q8.size() == 0) begin
                    check_eq("spurious_done8", 32'(done8), 32'd0);
                end else begin
                    em = q8.pop_front();
                    check_eq("roles8", 32'(roles8), em.roles);
                    check_eq("lat8", 32'(cyc - em.st), 32'(em.lat));
                    check_eq("bound8", 32'(cyc - em.st + 1 <= 18), 32'd1);
                    check_eq("wolves8", count_code(32'(roles8), 8, 2'b01), 32'd2);
                    check_eq("doctors8", count_code(32'(roles8), 8, 2'b10), 32'd1);
                    if (em.fb) fb_seen++;
                end
            end
        end
    end

    initial begin
        #12;
        check_eq("rst_roles5", 32'(roles5), 32'd0);
        check_eq("rst_busy5", 32'(busy5), 32'd0);
        check_eq("rst_done5", 32'(done5), 32'd0);
        check_eq("rst_roles8", 32'(roles8), 32'd0);
        check_eq("rst_busy8", 32'(busy8), 32'd0);
        #5 reset_n = 1'b1;

        // Deal from the reset LFSR value, then from a loaded seed.
        deal(1'b0, 16'h0000, 1'b0);
        deal(1'b1, 16'hACE1, 1'b0);
        ra = last_roles5;

        // Same seed after a reset must reproduce the same roles.
        apply_reset();
        deal(1'b1, 16'hACE1, 1'b0);
        rb = last_roles5;
        check_eq("repeat_acE1", 32'(rb), 32'(ra));

        // A zero seed behaves like a seed of one.
        deal(1'b1, 16'h0000, 1'b0);
        ra = last_roles5;
        deal(1'b1, 16'h0001, 1'b0);
        check_eq("seed0_eq_seed1", 32'(last_roles5), 32'(ra));

        // start/seed_load during PLACE are ignored; the follow-on deal continues the LFSR.
        deal(1'b1, 16'h5A5A, 1'b1);
        deal(1'b0, 16'h0000, 1'b0);

        // Reset mid-PLACE clears outputs asynchronously.
        skip_mon = 1'b1;
        @(posedge clock); #1;
        seed = 16'hBEEF; seed_load = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        seed_load = 1'b0; start = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check_eq("midrst_roles5", 32'(roles5), 32'd0);
        check_eq("midrst_busy5", 32'(busy5), 32'd0);
        check_eq("midrst_done5", 32'(done5), 32'd0);
        check_eq("midrst_roles8", 32'(roles8), 32'd0);
        check_eq("midrst_busy8", 32'(busy8), 32'd0);
        q5.delete(); q8.delete();
        active5 = 1'b0; m5 = 16'h1; m8 = 16'h1;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        skip_mon = 1'b0;
        deal(1'b1, 16'hBEEF, 1'b0);

        for (int i = 0; i < 1000; i++) deal(1'b1, 16'($urandom), 1'b0);
        check_eq("fallback_cov", 32'(fb_seen > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
